// File: rtl/mem_test_pkg.sv
// Types and pattern helpers shared by the memory-test reader and writer engines.
package mem_test_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SET_PARA,
    XFER_DATA,
    XFER_WAIT
  } state_t;

  localparam int unsigned PATTERN_W = 8;

  function automatic int unsigned lanes_per_beat(input int unsigned data_w);
    return data_w / PATTERN_W;
  endfunction

  // Test pattern: byte k of the buffer holds k mod 256.
  function automatic logic [PATTERN_W-1:0] pattern_byte(input logic [31:0] idx);
    return idx[PATTERN_W-1:0];
  endfunction

endpackage

// File: rtl/mem_pattern_cmp.sv
// Builds the expected pattern beat for the current pattern pointer and flags any
// byte lane of the incoming beat that differs from it.
module mem_pattern_cmp
  import mem_test_pkg::*;
#(
  parameter int unsigned DATA_W             = 256,
  parameter int unsigned PTR_W              = 10,
  parameter int unsigned MEM_DATA_COUNT     = 1024,
  parameter int unsigned MEM_DATA_ADDR_SIZE = 8
) (
  input  logic [PTR_W-1:0]  rd_ptr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              mismatch_c_o
);

  localparam int unsigned LANES = lanes_per_beat(DATA_W);
  localparam logic [31:0] ELEM_MASK = (MEM_DATA_ADDR_SIZE >= 32) ? 32'hFFFF_FFFF :
                                      32'((64'd1 << MEM_DATA_ADDR_SIZE) - 64'd1);

  logic [DATA_W-1:0] exp_c;

  always_comb begin
    exp_c = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      exp_c[i*PATTERN_W +: PATTERN_W] =
        pattern_byte(((32'(rd_ptr_i) + 32'(i)) % 32'(MEM_DATA_COUNT)) & ELEM_MASK);
    end
  end

  assign mismatch_c_o = (data_i != exp_c);

endmodule

// File: rtl/mem_read.sv
// Memory-test read engine: walks read commands over the buffer and checks the returned
// stream against the writer's pattern. Define MEM_READ_ERR_CAPTURE_EN to capture the first bad beat.
module mem_read
  import mem_test_pkg::*;
#(
  parameter int unsigned C_AXIS_TDATA_WIDTH          = 256,
  parameter int unsigned C_M_AXI_ADDR_WIDTH          = 64,
  parameter int unsigned C_XFER_SIZE_WIDTH           = 32,
  parameter int unsigned READ_DATA_SIZE              = 32,
  parameter int unsigned READ_BASE_ADDRESS_WIDTH     = 64,
  parameter int unsigned READ_ADDRESS_INCREMENT_SIZE = 32,
  parameter int unsigned READ_MEM_MAX_ADDR_SIZE      = 32,
  parameter int unsigned MEM_DATA_COUNT              = 1024,
  parameter int unsigned MEM_DATA_ADDR_SIZE          = 8,
  parameter int unsigned CNT_WIDTH                   = 32
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [READ_BASE_ADDRESS_WIDTH-1:0]     in_data_base_addr,
  input  logic [READ_ADDRESS_INCREMENT_SIZE-1:0] addr_increment,
  input  logic [READ_MEM_MAX_ADDR_SIZE-1:0]      mem_max_addr,
  output logic                                   done,
  output logic                                   read_in_data,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]          read_addr,
  output logic [C_XFER_SIZE_WIDTH-1:0]           in_data_size,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]          in_data,
  input  logic                                   in_data_valid,
  output logic                                   in_data_ready,
  input  logic                                   read_done,
  output logic [CNT_WIDTH-1:0]                   err_count,
  output logic [CNT_WIDTH-1:0]                   beat_count
`ifdef MEM_READ_ERR_CAPTURE_EN
  ,
  output logic                                   first_err_valid,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]          first_err_addr,
  output logic [C_AXIS_TDATA_WIDTH-1:0]          first_err_data
`endif
);

  localparam int unsigned LANES  = lanes_per_beat(C_AXIS_TDATA_WIDTH);
  localparam int unsigned BEATS  = READ_DATA_SIZE * 8 / C_AXIS_TDATA_WIDTH;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned PTR_W  = (MEM_DATA_COUNT > 1) ? $clog2(MEM_DATA_COUNT) : 1;
  localparam int unsigned SUM_W  = ((READ_ADDRESS_INCREMENT_SIZE > READ_MEM_MAX_ADDR_SIZE) ?
                                    READ_ADDRESS_INCREMENT_SIZE : READ_MEM_MAX_ADDR_SIZE) + 1;

  state_t                              state_q;
  logic                                done_q;
  logic                                read_in_data_q;
  logic [C_M_AXI_ADDR_WIDTH-1:0]       read_addr_q;
  logic [C_XFER_SIZE_WIDTH-1:0]        in_data_size_q;
  logic [READ_MEM_MAX_ADDR_SIZE-1:0]   mem_addr_q;
  logic [PTR_W-1:0]                    rd_ptr_q;
  logic [BEAT_W-1:0]                   beat_ctr_q;
  logic [CNT_WIDTH-1:0]                err_count_q;
  logic [CNT_WIDTH-1:0]                beat_count_q;

  logic [SUM_W-1:0]                    next_off_d;
  logic                                stop_d;
  logic                                accept_d;
  logic                                last_beat_d;
  logic [PTR_W-1:0]                    rd_ptr_d;
  logic [CNT_WIDTH-1:0]                err_count_d;
  logic [CNT_WIDTH-1:0]                beat_count_d;
  logic                                mismatch_c;

  mem_pattern_cmp #(
    .DATA_W            (C_AXIS_TDATA_WIDTH),
    .PTR_W             (PTR_W),
    .MEM_DATA_COUNT    (MEM_DATA_COUNT),
    .MEM_DATA_ADDR_SIZE(MEM_DATA_ADDR_SIZE)
  ) u_cmp (
    .rd_ptr_i    (rd_ptr_q),
    .data_i      (in_data),
    .mismatch_c_o(mismatch_c)
  );

  // Offset sum is one bit wider so a large increment cannot wrap past the bound.
  always_comb begin
    next_off_d   = SUM_W'(addr_increment) + SUM_W'(mem_addr_q);
    stop_d       = (mem_max_addr == '0) || (addr_increment == '0) ||
                   (next_off_d > SUM_W'(mem_max_addr));
    accept_d     = in_data_valid && in_data_ready;
    last_beat_d  = (beat_ctr_q == BEAT_W'(BEATS - 1));
    rd_ptr_d     = PTR_W'((32'(rd_ptr_q) + 32'(LANES)) % 32'(MEM_DATA_COUNT));
    err_count_d  = (err_count_q == '1) ? err_count_q : err_count_q + CNT_WIDTH'(1);
    beat_count_d = (beat_count_q == '1) ? beat_count_q : beat_count_q + CNT_WIDTH'(1);
  end

`ifdef MEM_READ_ERR_CAPTURE_EN
  logic                          first_err_valid_q;
  logic [C_M_AXI_ADDR_WIDTH-1:0] first_err_addr_q;
  logic [C_AXIS_TDATA_WIDTH-1:0] first_err_data_q;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= IDLE;
      done_q         <= 1'b0;
      read_in_data_q <= 1'b0;
      read_addr_q    <= '0;
      in_data_size_q <= '0;
      mem_addr_q     <= '0;
      rd_ptr_q       <= '0;
      beat_ctr_q     <= '0;
      err_count_q    <= '0;
      beat_count_q   <= '0;
`ifdef MEM_READ_ERR_CAPTURE_EN
      first_err_valid_q <= 1'b0;
      first_err_addr_q  <= '0;
      first_err_data_q  <= '0;
`endif
    end else begin
      done_q         <= 1'b0;
      read_in_data_q <= 1'b0;
      case (state_q)
        IDLE: begin
          read_addr_q    <= '0;
          in_data_size_q <= '0;
          mem_addr_q     <= '0;
          rd_ptr_q       <= '0;
          beat_ctr_q     <= '0;
          if (start) begin
            err_count_q  <= '0;
            beat_count_q <= '0;
            state_q      <= SET_PARA;
`ifdef MEM_READ_ERR_CAPTURE_EN
            first_err_valid_q <= 1'b0;
            first_err_addr_q  <= '0;
            first_err_data_q  <= '0;
`endif
          end
        end
        SET_PARA: begin
          if (stop_d) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            read_addr_q    <= C_M_AXI_ADDR_WIDTH'(in_data_base_addr) +
                              C_M_AXI_ADDR_WIDTH'(mem_addr_q);
            in_data_size_q <= C_XFER_SIZE_WIDTH'(READ_DATA_SIZE);
            read_in_data_q <= 1'b1;
            mem_addr_q     <= next_off_d[READ_MEM_MAX_ADDR_SIZE-1:0];
            state_q        <= XFER_DATA;
          end
        end
        XFER_DATA: begin
          if (accept_d) begin
            beat_count_q <= beat_count_d;
            rd_ptr_q     <= rd_ptr_d;
            if (mismatch_c) err_count_q <= err_count_d;
`ifdef MEM_READ_ERR_CAPTURE_EN
            if (mismatch_c && !first_err_valid_q) begin
              first_err_valid_q <= 1'b1;
              first_err_addr_q  <= read_addr_q + C_M_AXI_ADDR_WIDTH'(beat_ctr_q) *
                                   C_M_AXI_ADDR_WIDTH'(LANES);
              first_err_data_q  <= in_data;
            end
`endif
            if (last_beat_d) begin
              beat_ctr_q <= '0;
              state_q    <= XFER_WAIT;
            end else begin
              beat_ctr_q <= beat_ctr_q + BEAT_W'(1);
            end
          end
        end
        XFER_WAIT: begin
          if (read_done) state_q <= SET_PARA;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_data_ready = (state_q == XFER_DATA);
  assign done          = done_q;
  assign read_in_data  = read_in_data_q;
  assign read_addr     = read_addr_q;
  assign in_data_size  = in_data_size_q;
  assign err_count     = err_count_q;
  assign beat_count    = beat_count_q;
`ifdef MEM_READ_ERR_CAPTURE_EN
  assign first_err_valid = first_err_valid_q;
  assign first_err_addr  = first_err_addr_q;
  assign first_err_data  = first_err_data_q;
`endif

endmodule

// File: tb/tb_mem_read.sv
// Self-checking bench for mem_read: an emulated read master returns the pattern stream,
// expected commands are queued per scenario and compared against the observed ones.
module tb_mem_read;

  localparam int DW    = 256;
  localparam int AW    = 64;
  localparam int SW    = 32;
  localparam int RDS   = 32;
  localparam int MDC   = 1024;
  localparam int CW    = 32;
  localparam int LANES = DW / 8;
  localparam int BEATS = RDS * 8 / DW;

  typedef struct {
    logic [AW-1:0] addr;
    logic [SW-1:0] size;
  } cmd_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [63:0]   in_data_base_addr;
  logic [31:0]   addr_increment;
  logic [31:0]   mem_max_addr;
  logic          done;
  logic          read_in_data;
  logic [AW-1:0] read_addr;
  logic [SW-1:0] in_data_size;
  logic [DW-1:0] in_data;
  logic          in_data_valid;
  logic          in_data_ready;
  logic          read_done;
  logic [CW-1:0] err_count;
  logic [CW-1:0] beat_count;
`ifdef MEM_READ_ERR_CAPTURE_EN
  logic          first_err_valid;
  logic [AW-1:0] first_err_addr;
  logic [DW-1:0] first_err_data;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  cmd_t          obs_q[$];
  logic [AW-1:0] exp_q[$];

  bit cfg_toggle       = 1'b0;
  int cfg_holdoff      = 0;
  int cfg_corrupt_cmd  = -1;
  int cfg_corrupt_byte = 0;
  int emu_ready_err    = 0;

  always #5 clk = ~clk;

  mem_read dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .in_data_base_addr(in_data_base_addr),
    .addr_increment   (addr_increment),
    .mem_max_addr     (mem_max_addr),
    .done             (done),
    .read_in_data     (read_in_data),
    .read_addr        (read_addr),
    .in_data_size     (in_data_size),
    .in_data          (in_data),
    .in_data_valid    (in_data_valid),
    .in_data_ready    (in_data_ready),
    .read_done        (read_done),
    .err_count        (err_count),
    .beat_count       (beat_count)
`ifdef MEM_READ_ERR_CAPTURE_EN
    ,
    .first_err_valid  (first_err_valid),
    .first_err_addr   (first_err_addr),
    .first_err_data   (first_err_data)
`endif
  );

  // Reference pattern: buffer byte k = k mod 256, pointer wraps every MDC bytes.
  function automatic logic [DW-1:0] beat_pattern(input int ptr);
    logic [DW-1:0] d;
    for (int k = 0; k < LANES; k++) d[k*8 +: 8] = 8'((ptr + k) % MDC);
    return d;
  endfunction

  function automatic int push_expected(input logic [63:0] base, input int inc, input int max);
    int cnt = 0;
    longint off = 0;
    if (inc == 0 || max == 0) return 0;
    while (off + longint'(inc) <= longint'(max)) begin
      exp_q.push_back(base + 64'(off));
      off += longint'(inc);
      cnt++;
    end
    return cnt;
  endfunction

  // Read-master emulator: records commands, returns pattern beats, pulses read_done.
  initial begin : emu
    int ptr = 0, beats_left = 0, cmd_idx = 0, cur_cmd = 0, beat_idx = 0;
    int done_cnt = 0, holdoff = 0;
    bit phase = 1'b0, last = 1'b0;
    logic [DW-1:0] d;
    in_data_valid = 1'b0;
    in_data       = '0;
    read_done     = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      read_done = 1'b0;
      if (!reset) begin
        in_data_valid = 1'b0;
        beats_left = 0;
        done_cnt   = 0;
        last       = 1'b0;
      end else begin
        if (start) begin
          ptr = 0;
          cmd_idx = 0;
          obs_q.delete();
        end
        if (last) begin
          if (in_data_ready) emu_ready_err++;
          last = 1'b0;
        end
        if (done_cnt > 0) begin
          done_cnt--;
          if (done_cnt == 0) read_done = 1'b1;
        end
        if (read_in_data) begin
          obs_q.push_back('{read_addr, in_data_size});
          beats_left = BEATS;
          holdoff    = cfg_holdoff;
          phase      = cfg_toggle;
          cur_cmd    = cmd_idx;
          cmd_idx++;
          beat_idx   = 0;
        end
        in_data_valid = 1'b0;
        in_data       = ~beat_pattern(ptr);
        if (beats_left > 0) begin
          if (!in_data_ready) emu_ready_err++;
          if (holdoff > 0) begin
            holdoff--;
          end else if (phase) begin
            phase = 1'b0;
          end else begin
            d = beat_pattern(ptr);
            if (cur_cmd == cfg_corrupt_cmd && beat_idx == 0)
              d[cfg_corrupt_byte*8 +: 8] = d[cfg_corrupt_byte*8 +: 8] ^ 8'hFF;
            in_data       = d;
            in_data_valid = 1'b1;
            phase         = cfg_toggle;
            ptr           = (ptr + LANES) % MDC;
            beat_idx++;
            beats_left--;
            if (beats_left == 0) begin
              done_cnt = 2;
              last     = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic wait_done(input int limit, output bit seen);
    seen = 1'b0;
    for (int n = 0; n < limit && !seen; n++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    n_checks += 8;
    if (done !== 1'b0)          begin n_fail++; $display("FAIL reset_done: got %0b, expected 0", done); end
    if (read_in_data !== 1'b0)  begin n_fail++; $display("FAIL reset_read_in_data: got %0b, expected 0", read_in_data); end
    if (read_addr !== '0)       begin n_fail++; $display("FAIL reset_read_addr: got %0h, expected 0", read_addr); end
    if (in_data_size !== '0)    begin n_fail++; $display("FAIL reset_size: got %0h, expected 0", in_data_size); end
    if (in_data_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %0b, expected 0", in_data_ready); end
    if (err_count !== '0)       begin n_fail++; $display("FAIL reset_err_count: got %0d, expected 0", err_count); end
    if (beat_count !== '0)      begin n_fail++; $display("FAIL reset_beat_count: got %0d, expected 0", beat_count); end
`ifdef MEM_READ_ERR_CAPTURE_EN
    if (first_err_valid !== 1'b0) begin n_fail++; $display("FAIL reset_first_err_valid: got %0b, expected 0", first_err_valid); end
`else
    n_checks--;
`endif
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic(input logic [63:0] base);
    bit seen;
    int n, exp_n, rerr0;
    logic [AW-1:0] e;
    in_data_base_addr = base;
    addr_increment    = 32;
    mem_max_addr      = 96;
    exp_n = push_expected(base, 32, 96);
    rerr0 = emu_ready_err;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (read_in_data !== 1'b0) begin n_fail++; $display("FAIL basic_latency1: got %0b, expected 0", read_in_data); end
    @(negedge clk);
    n_checks++;
    if (read_in_data !== 1'b1 || read_addr !== base) begin
      n_fail++; $display("FAIL basic_first_cmd: got strobe %0b addr %0h, expected 1 addr %0h", read_in_data, read_addr, base);
    end
    wait_done(200, seen);
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL basic_done: got no done within bound, expected done"); end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_width: got %0b, expected 0", done); end
    n = obs_q.size();
    n_checks++;
    if (n != exp_n) begin n_fail++; $display("FAIL basic_cmd_count: got %0d, expected %0d", n, exp_n); end
    for (int i = 0; i < n && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q[i].addr !== e || obs_q[i].size !== SW'(RDS)) begin
        n_fail++; $display("FAIL basic_cmd%0d: got addr %0h size %0d, expected addr %0h size %0d", i, obs_q[i].addr, obs_q[i].size, e, RDS);
      end
    end
    exp_q.delete();
    repeat (3) @(negedge clk);
    n_checks += 3;
    if (beat_count !== CW'(3)) begin n_fail++; $display("FAIL basic_beat_count: got %0d, expected 3", beat_count); end
    if (err_count !== CW'(0))  begin n_fail++; $display("FAIL basic_err_count: got %0d, expected 0", err_count); end
    if (emu_ready_err != rerr0) begin n_fail++; $display("FAIL basic_ready: got %0d ready faults, expected 0", emu_ready_err - rerr0); end
`ifdef MEM_READ_ERR_CAPTURE_EN
    n_checks++;
    if (first_err_valid !== 1'b0) begin n_fail++; $display("FAIL basic_first_err_valid: got %0b, expected 0", first_err_valid); end
`endif
  endtask

  task automatic test_corrupt();
    bit seen;
    int n;
    logic [AW-1:0] e;
    logic [DW-1:0] bad;
    cfg_corrupt_cmd   = 1;
    cfg_corrupt_byte  = 5;
    in_data_base_addr = 64'h1000;
    addr_increment    = 32;
    mem_max_addr      = 96;
    void'(push_expected(64'h1000, 32, 96));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(200, seen);
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL corrupt_done: got no done within bound, expected done"); end
    n = obs_q.size();
    for (int i = 0; i < n && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q[i].addr !== e) begin n_fail++; $display("FAIL corrupt_cmd%0d: got %0h, expected %0h", i, obs_q[i].addr, e); end
    end
    exp_q.delete();
    n_checks += 2;
    if (err_count !== CW'(1))  begin n_fail++; $display("FAIL corrupt_err_count: got %0d, expected 1", err_count); end
    if (beat_count !== CW'(3)) begin n_fail++; $display("FAIL corrupt_beat_count: got %0d, expected 3", beat_count); end
`ifdef MEM_READ_ERR_CAPTURE_EN
    bad = beat_pattern(32);
    bad[5*8 +: 8] = bad[5*8 +: 8] ^ 8'hFF;
    n_checks += 3;
    if (first_err_valid !== 1'b1) begin n_fail++; $display("FAIL corrupt_first_err_valid: got %0b, expected 1", first_err_valid); end
    if (first_err_addr !== 64'h1020) begin n_fail++; $display("FAIL corrupt_first_err_addr: got %0h, expected 1020", first_err_addr); end
    if (first_err_data !== bad) begin n_fail++; $display("FAIL corrupt_first_err_data: got %0h, expected %0h", first_err_data, bad); end
`else
    bad = '0;
    if (bad !== '0) $display("unreachable");
`endif
    cfg_corrupt_cmd = -1;
    @(negedge clk);
  endtask

  task automatic test_degenerate();
    for (int c = 0; c < 2; c++) begin
      in_data_base_addr = 64'h1000;
      addr_increment    = (c == 0) ? 32'd32 : 32'd0;
      mem_max_addr      = (c == 0) ? 32'd0 : 32'd96;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL degen%0d_done_early: got %0b, expected 0", c, done); end
      @(negedge clk);
      n_checks += 2;
      if (done !== 1'b1) begin n_fail++; $display("FAIL degen%0d_done: got %0b, expected 1", c, done); end
      if (obs_q.size() != 0) begin n_fail++; $display("FAIL degen%0d_cmds: got %0d, expected 0", c, obs_q.size()); end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL degen%0d_done_width: got %0b, expected 0", c, done); end
    end
  endtask

  task automatic test_wrap();
    bit seen;
    int n, exp_n, bad_cmds = 0;
    logic [AW-1:0] e;
    in_data_base_addr = 64'h0000_0001_0000_0000;
    addr_increment    = 32;
    mem_max_addr      = 2048;
    exp_n = push_expected(64'h0000_0001_0000_0000, 32, 2048);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(4000, seen);
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL wrap_done: got no done within bound, expected done"); end
    n = obs_q.size();
    n_checks++;
    if (n != exp_n) begin n_fail++; $display("FAIL wrap_cmd_count: got %0d, expected %0d", n, exp_n); end
    for (int i = 0; i < n && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      if (obs_q[i].addr !== e) bad_cmds++;
    end
    exp_q.delete();
    n_checks += 3;
    if (bad_cmds != 0) begin n_fail++; $display("FAIL wrap_cmd_addr: got %0d wrong addresses, expected 0", bad_cmds); end
    if (beat_count !== CW'(exp_n)) begin n_fail++; $display("FAIL wrap_beat_count: got %0d, expected %0d", beat_count, exp_n); end
    if (err_count !== CW'(0)) begin n_fail++; $display("FAIL wrap_err_count: got %0d, expected 0", err_count); end
    @(negedge clk);
  endtask

  task automatic test_valid_toggle();
    bit seen;
    int rerr0, exp_n;
    cfg_toggle        = 1'b1;
    in_data_base_addr = 64'h2000;
    addr_increment    = 64;
    mem_max_addr      = 256;
    exp_n = push_expected(64'h2000, 64, 256);
    rerr0 = emu_ready_err;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(400, seen);
    n_checks += 5;
    if (!seen) begin n_fail++; $display("FAIL toggle_done: got no done within bound, expected done"); end
    if (obs_q.size() != exp_n) begin n_fail++; $display("FAIL toggle_cmd_count: got %0d, expected %0d", obs_q.size(), exp_n); end
    if (beat_count !== CW'(4)) begin n_fail++; $display("FAIL toggle_beat_count: got %0d, expected 4", beat_count); end
    if (err_count !== CW'(0)) begin n_fail++; $display("FAIL toggle_err_count: got %0d, expected 0", err_count); end
    if (emu_ready_err != rerr0) begin n_fail++; $display("FAIL toggle_ready: got %0d ready faults, expected 0", emu_ready_err - rerr0); end
    exp_q.delete();
    cfg_toggle = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    int pulses = 0;
    cfg_holdoff       = 3;
    in_data_base_addr = 64'h3000;
    addr_increment    = 32;
    mem_max_addr      = 96;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      if (obs_q.size() >= 2) found = 1'b1;
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL midrst_second_cmd: got %0d commands, expected 2", obs_q.size()); end
    reset = 1'b0;
    @(negedge clk);
    n_checks += 6;
    if (done !== 1'b0 || read_in_data !== 1'b0) begin n_fail++; $display("FAIL midrst_strobes: got done %0b cmd %0b, expected 0 0", done, read_in_data); end
    if (read_addr !== '0)       begin n_fail++; $display("FAIL midrst_read_addr: got %0h, expected 0", read_addr); end
    if (in_data_size !== '0)    begin n_fail++; $display("FAIL midrst_size: got %0h, expected 0", in_data_size); end
    if (in_data_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %0b, expected 0", in_data_ready); end
    if (err_count !== '0)       begin n_fail++; $display("FAIL midrst_err_count: got %0d, expected 0", err_count); end
    if (beat_count !== '0)      begin n_fail++; $display("FAIL midrst_beat_count: got %0d, expected 0", beat_count); end
    @(negedge clk);
    reset = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done === 1'b1 || read_in_data === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin n_fail++; $display("FAIL midrst_idle: got %0d pulses, expected 0", pulses); end
    cfg_holdoff = 0;
    test_basic(64'h5000);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin : main
    reset             = 1'b0;
    start             = 1'b0;
    in_data_base_addr = '0;
    addr_increment    = '0;
    mem_max_addr      = '0;
    test_reset();
    test_basic(64'h1000);
    test_corrupt();
    test_degenerate();
    test_wrap();
    test_valid_toggle();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
